idma_aw_credit_scheduler: RTL and testbench



---
 rtl/idma_aw_sched_pkg.sv | 16 +
 rtl/idma_credit_counter.sv | 30 +++
 rtl/idma_aw_credit_scheduler.sv | 102 ++++++++++
 tb/tb_idma_aw_credit_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_aw_sched_pkg.sv
// idma_aw_sched_pkg: shared types and helpers for the AW credit scheduler
package idma_aw_sched_pkg;

    typedef enum logic {IDLE, LOCKED} state_e;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    function automatic int unsigned cnt_width(input int unsigned max_in_flight);
        return $clog2(max_in_flight + 1);
    endfunction

endpackage

// File: rtl/idma_credit_counter.sv
// idma_credit_counter: saturating outstanding-write counter with underflow detection
module idma_credit_counter
    import idma_aw_sched_pkg::*;
#(
    parameter int unsigned MaxInFlight = 4,
    localparam int unsigned CntW = cnt_width(MaxInFlight)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            err_o
);

    logic [CntW-1:0] cnt_q;

    assign cnt_o  = cnt_q;
    assign full_o = cnt_q == CntW'(MaxInFlight);
    assign err_o  = dec_i && cnt_q == '0;

    // a paired inc/dec cancels; an erroneous dec leaves the count untouched
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (inc_i && !dec_i && !full_o) cnt_q <= cnt_q + CntW'(1);
        else if (dec_i && !inc_i && !err_o) cnt_q <= cnt_q - CntW'(1);
    end

endmodule

// File: rtl/idma_aw_credit_scheduler.sv
// idma_aw_credit_scheduler: round-robin, credit-limited sharing of one AXI AW port
module idma_aw_credit_scheduler
    import idma_aw_sched_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned MaxInFlight = 4,
    parameter int unsigned AxiIdWidth  = 2,
    parameter type axi_aw_chan_t = aw_chan_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  axi_aw_chan_t           aw_req_i [NumChannels],
    input  logic [NumChannels-1:0] aw_valid_i,
    output logic [NumChannels-1:0] aw_ready_o,
    output axi_aw_chan_t           aw_req_o,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    input  logic                   b_valid_i,
    input  logic                   b_ready_i,
    input  logic [AxiIdWidth-1:0]  b_id_i,
    output logic [NumChannels-1:0] credit_empty_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int unsigned IdxW = $clog2(NumChannels);

    state_e                 state_q;
    logic [IdxW-1:0]        rr_q, gnt_q, win, gnt, idx;
    logic                   win_vld, gnt_vld, aw_hs, b_hs, b_bad, err_q;
    logic [NumChannels-1:0] elig, full, inc, dec, cnt_err, nz;

    assign elig = aw_valid_i & ~full;

    // scan downwards so the lowest offset from rr_q is the last, winning assignment
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = NumChannels - 1; k >= 0; k--) begin
            idx = IdxW'((int'(rr_q) + k) % NumChannels);
            if (elig[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign gnt     = (state_q == LOCKED) ? gnt_q : win;
    assign gnt_vld = (state_q == LOCKED) ? aw_valid_i[gnt_q] : win_vld;
    assign aw_hs   = gnt_vld && aw_ready_i;
    assign b_hs    = b_valid_i && b_ready_i;
    assign b_bad   = b_hs && 32'(b_id_i) >= NumChannels;

    always_comb begin
        aw_req_o              = aw_req_i[gnt];
        aw_req_o.id           = '0;
        aw_req_o.id[IdxW-1:0] = gnt;
    end

    assign aw_valid_o     = gnt_vld;
    assign credit_empty_o = full;
    assign err_o          = err_q;
    assign busy_o         = aw_valid_o || |nz;

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        logic [cnt_width(MaxInFlight)-1:0] cnt;
        assign aw_ready_o[i] = aw_hs && gnt == IdxW'(i);
        assign inc[i]        = aw_hs && gnt == IdxW'(i);
        assign dec[i]        = b_hs && b_id_i == AxiIdWidth'(i);
        assign nz[i]         = |cnt;
        idma_credit_counter #(.MaxInFlight(MaxInFlight)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (inc[i]),
            .dec_i  (dec[i]),
            .cnt_o  (cnt),
            .full_o (full[i]),
            .err_o  (cnt_err[i])
        );
    end

    // the lock holds a stalled grant so valid and payload stay stable until accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_q || b_bad || |cnt_err;
            if (aw_hs) rr_q <= (gnt == IdxW'(NumChannels - 1)) ? '0 : gnt + IdxW'(1);
            if (state_q == IDLE && win_vld && !aw_ready_i) begin
                state_q <= LOCKED;
                gnt_q   <= win;
            end else if (state_q == LOCKED && aw_hs) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_idma_aw_credit_scheduler.sv
// tb_idma_aw_credit_scheduler: directed checks of arbitration, lock, credits and errors
module tb_idma_aw_credit_scheduler;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] addr;
    } aw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aw_t        req [2];
    aw_t        req_o;
    logic [1:0] vld, rdy_o, empty, bid;
    logic       vld_o, rdy_i, bv, br, err, busy;

    aw_t        f_req [3];
    aw_t        f_req_o;
    logic [2:0] f_vld, f_rdy_o, f_empty;
    logic       f_vld_o, f_rdy_i, f_err, f_busy;

    int checks = 0;
    int errors = 0;

    idma_aw_credit_scheduler #(
        .NumChannels(2), .MaxInFlight(4), .AxiIdWidth(2), .axi_aw_chan_t(aw_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .aw_req_i(req), .aw_valid_i(vld), .aw_ready_o(rdy_o),
        .aw_req_o(req_o), .aw_valid_o(vld_o), .aw_ready_i(rdy_i), .b_valid_i(bv),
        .b_ready_i(br), .b_id_i(bid), .credit_empty_o(empty), .err_o(err), .busy_o(busy)
    );

    idma_aw_credit_scheduler #(
        .NumChannels(3), .MaxInFlight(4), .AxiIdWidth(2), .axi_aw_chan_t(aw_t)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .aw_req_i(f_req), .aw_valid_i(f_vld), .aw_ready_o(f_rdy_o),
        .aw_req_o(f_req_o), .aw_valid_o(f_vld_o), .aw_ready_i(f_rdy_i), .b_valid_i(1'b0),
        .b_ready_i(1'b0), .b_id_i(2'b00), .credit_empty_o(f_empty), .err_o(f_err), .busy_o(f_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        vld = '0; rdy_i = 1'b0; bv = 1'b0; br = 1'b0; bid = '0;
        f_vld = '0; f_rdy_i = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        vld = '0; rdy_i = 1'b1; bv = 1'b0; br = 1'b0; bid = '0;
        #1;
        checks++;
        if ({vld_o, rdy_o, err, busy, empty} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b rdy=%b err=%b busy=%b empty=%b exp all 0",
                     vld_o, rdy_o, err, busy, empty);
        end
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if ({vld_o, rdy_o, err, busy, empty} !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_outputs got vld=%b rdy=%b err=%b busy=%b empty=%b exp all 0",
                     vld_o, rdy_o, err, busy, empty);
        end
    endtask

    task automatic test_fairness;
        do_reset;
        f_vld = 3'b111; f_rdy_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (f_vld_o !== 1'b1 || f_req_o.id !== 2'(c % 3) || f_req_o.addr !== 16'hA000 + 16'(c % 3)) begin
                errors++;
                $display("FAIL fair_grant%0d got vld=%b id=%0d addr=%h exp vld=1 id=%0d", c, f_vld_o,
                         f_req_o.id, f_req_o.addr, c % 3);
            end
            if (c == 6) begin
                checks++;
                if (f_empty !== 3'b000) begin
                    errors++;
                    $display("FAIL fair_half_empty got %b exp 000", f_empty);
                end
            end
            tick;
        end
        #1;
        checks++;
        if (f_empty !== 3'b111 || f_vld_o !== 1'b0 || f_busy !== 1'b1) begin
            errors++;
            $display("FAIL fair_full got empty=%b vld=%b busy=%b exp 111 0 1", f_empty, f_vld_o, f_busy);
        end
        f_vld = '0;
    endtask

    task automatic test_lock;
        do_reset;
        vld = 2'b10; rdy_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) vld = 2'b11;
            #1;
            checks++;
            if (vld_o !== 1'b1 || req_o.id !== 2'd1 || req_o.addr !== 16'hA001 || rdy_o !== 2'b00) begin
                errors++;
                $display("FAIL lock_hold%0d got vld=%b id=%0d addr=%h rdy=%b exp 1 1 a001 00", c, vld_o,
                         req_o.id, req_o.addr, rdy_o);
            end
            tick;
        end
        rdy_i = 1'b1;
        #1;
        checks++;
        if (rdy_o !== 2'b10 || req_o.id !== 2'd1) begin
            errors++;
            $display("FAIL lock_release got rdy=%b id=%0d exp 10 1", rdy_o, req_o.id);
        end
        tick;
        checks++;
        if (req_o.id !== 2'd0 || rdy_o !== 2'b01) begin
            errors++;
            $display("FAIL lock_rr_next got id=%0d rdy=%b exp 0 01", req_o.id, rdy_o);
        end
        tick;
        checks++;
        if (req_o.id !== 2'd1 || req_o.addr !== 16'hA001) begin
            errors++;
            $display("FAIL lock_rr_wrap got id=%0d addr=%h exp 1 a001", req_o.id, req_o.addr);
        end
    endtask

    task automatic test_credit_exhaustion;
        do_reset;
        vld = 2'b01; rdy_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (vld_o !== 1'b1 || req_o.id !== 2'd0) begin
                errors++;
                $display("FAIL credit_issue%0d got vld=%b id=%0d exp 1 0", c, vld_o, req_o.id);
            end
            tick;
        end
        #1;
        checks++;
        if (empty !== 2'b01 || vld_o !== 1'b0 || rdy_o !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL credit_stall got empty=%b vld=%b rdy=%b busy=%b exp 01 0 00 1", empty, vld_o,
                     rdy_o, busy);
        end
        bv = 1'b1; br = 1'b1; bid = 2'd0;
        #1;
        checks++;
        if (vld_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_no_bypass got vld=%b exp 0", vld_o);
        end
        tick;
        bv = 1'b0;
        #1;
        checks++;
        if (vld_o !== 1'b1 || empty !== 2'b00) begin
            errors++;
            $display("FAIL credit_returned got vld=%b empty=%b exp 1 00", vld_o, empty);
        end
        tick;
        checks++;
        if (empty !== 2'b01) begin
            errors++;
            $display("FAIL credit_refull got empty=%b exp 01", empty);
        end
    endtask

    task automatic test_simultaneous;
        do_reset;
        vld = 2'b10; rdy_i = 1'b1;
        tick;
        tick;
        bv = 1'b1; br = 1'b1; bid = 2'd1;
        #1;
        checks++;
        if (vld_o !== 1'b1 || req_o.id !== 2'd1) begin
            errors++;
            $display("FAIL simul_grant got vld=%b id=%0d exp 1 1", vld_o, req_o.id);
        end
        tick;
        bv = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (empty !== 2'b00 || err !== 1'b0) begin
                errors++;
                $display("FAIL simul_cnt%0d got empty=%b err=%b exp 00 0", c, empty, err);
            end
            tick;
        end
        checks++;
        if (empty !== 2'b10 || vld_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_full got empty=%b vld=%b exp 10 0", empty, vld_o);
        end
    endtask

    task automatic test_errors;
        do_reset;
        vld = 2'b01; rdy_i = 1'b1;
        repeat (4) tick;
        vld = '0;
        bv = 1'b1; br = 1'b1; bid = 2'd3;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_before got %b exp 0", err);
        end
        tick;
        bv = 1'b0;
        checks++;
        if (err !== 1'b1 || empty !== 2'b01) begin
            errors++;
            $display("FAIL err_bad_id got err=%b empty=%b exp 1 01", err, empty);
        end
        do_reset;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got %b exp 0", err);
        end
        bv = 1'b1; br = 1'b1; bid = 2'd0;
        tick;
        bv = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_underflow got err=%b busy=%b exp 1 0", err, busy);
        end
        vld = 2'b01; rdy_i = 1'b1;
        repeat (3) tick;
        checks++;
        if (empty !== 2'b00) begin
            errors++;
            $display("FAIL err_cnt_three got empty=%b exp 00", empty);
        end
        tick;
        checks++;
        if (empty !== 2'b01 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_cnt_four got empty=%b err=%b exp 01 1", empty, err);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        rdy_i = 1'b1;
        vld = 2'b10;
        tick;
        vld = 2'b01;
        repeat (3) tick;
        vld = 2'b10; rdy_i = 1'b0;
        tick;
        vld = 2'b11;
        #1;
        checks++;
        if (vld_o !== 1'b1 || req_o.id !== 2'd1) begin
            errors++;
            $display("FAIL mid_locked got vld=%b id=%0d exp 1 1", vld_o, req_o.id);
        end
        #1;
        rst_n = 1'b0;
        vld = '0;
        #1;
        checks++;
        if ({vld_o, rdy_o, err, busy, empty} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset got vld=%b rdy=%b err=%b busy=%b empty=%b exp all 0",
                     vld_o, rdy_o, err, busy, empty);
        end
        tick;
        rst_n = 1'b1;
        vld = 2'b11; rdy_i = 1'b1;
        #1;
        checks++;
        if (req_o.id !== 2'd0 || rdy_o !== 2'b01) begin
            errors++;
            $display("FAIL mid_after_id got id=%0d rdy=%b exp 0 01", req_o.id, rdy_o);
        end
        tick;
        vld = 2'b01;
        repeat (2) tick;
        checks++;
        if (empty !== 2'b00) begin
            errors++;
            $display("FAIL mid_cnt_cleared got empty=%b exp 00", empty);
        end
        tick;
        checks++;
        if (empty !== 2'b01) begin
            errors++;
            $display("FAIL mid_cnt_full got empty=%b exp 01", empty);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) req[i] = '{id: 2'b11, addr: 16'hA000 + 16'(i)};
        for (int i = 0; i < 3; i++) f_req[i] = '{id: 2'b11, addr: 16'hA000 + 16'(i)};
        f_vld = '0; f_rdy_i = 1'b0;
        test_reset;
        test_fairness;
        test_lock;
        test_credit_exhaustion;
        test_simultaneous;
        test_errors;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
